ibex_mem_arbiter: RTL

Shares one single-port, one-cycle-read-latency SRAM between the Ibex instruction and data memory interfaces. It generates real grants and response-valid pulses, replacing the tied-high grants. Arbitration is round-robin or data-priority with a starvation guard, and the response is routed back to the port that issued the request. It sits between the core wrapper's memory ports and a unified `noift_sram_mem` instance.

---
 rtl/ibex_mem_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one single-port SRAM (one-cycle read latency)
// between the Ibex instruction and data ports. It produces real grants and
// rvalid pulses, and routes each response back to the port that issued it.
module ibex_mem_arbiter #(
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned DataWidth    = 32,
   parameter bit          DataPriority = 1'b0,
   parameter int unsigned StarveLimit  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,

   input  logic                 instr_req_i,
   input  logic [AddrWidth-1:0] instr_addr_i,
   output logic                 instr_gnt_o,
   output logic                 instr_rvalid_o,
   output logic [DataWidth-1:0] instr_rdata_o,

   input  logic                 data_req_i,
   input  logic                 data_we_i,
   input  logic [AddrWidth-1:0] data_addr_i,
   input  logic [DataWidth-1:0] data_wdata_i,
   input  logic [DataWidth-1:0] data_strb_i,
   output logic                 data_gnt_o,
   output logic                 data_rvalid_o,
   output logic [DataWidth-1:0] data_rdata_o,

   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [DataWidth-1:0] mem_strb_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   localparam logic [3:0] StarveMax = 4'(StarveLimit);

   // last_q: 0 = instr won the last grant, 1 = data won it
   logic       last_q;
   logic [3:0] starve_q;
   logic [3:0] starve_d;
   logic       pend_valid_q;
   logic       pend_owner_q;
   logic       contention;
   logic       instr_wins;
   logic       any_gnt;

   assign contention = instr_req_i & data_req_i;
   assign any_gnt    = instr_gnt_o | data_gnt_o;

   // Pick the winner: a lone requester always wins, contention is settled by mode.
   always_comb begin
      instr_wins  = 1'b0;
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      if (rst_ni) begin
         if (contention) begin
            if (DataPriority) begin
               instr_wins = (starve_q >= StarveMax);
            end else begin
               instr_wins = last_q;
            end
            instr_gnt_o = instr_wins;
            data_gnt_o  = ~instr_wins;
         end else begin
            instr_gnt_o = instr_req_i;
            data_gnt_o  = data_req_i;
         end
      end
   end

   // Starvation counter: counts instr losses, clears on instr grant, saturates at the limit.
   always_comb begin
      starve_d = starve_q;
      if (DataPriority) begin
         if (instr_gnt_o) begin
            starve_d = 4'd0;
         end else if (contention && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   // Arbitration history and the single outstanding response slot.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q       <= 1'b1;
         starve_q     <= 4'd0;
         pend_valid_q <= 1'b0;
         pend_owner_q <= 1'b0;
      end else begin
         starve_q     <= starve_d;
         pend_valid_q <= any_gnt;
         if (any_gnt) begin
            last_q       <= data_gnt_o;
            pend_owner_q <= data_gnt_o;
         end
      end
   end

   // Steer the winner's request onto the SRAM; fetches never write.
   always_comb begin
      mem_req_o   = rst_ni & (instr_req_i | data_req_i);
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_strb_o  = '0;
      if (instr_gnt_o) begin
         mem_addr_o  = instr_addr_i;
      end else if (data_gnt_o) begin
         mem_we_o    = data_we_i;
         mem_addr_o  = data_addr_i;
         mem_wdata_o = data_wdata_i;
         mem_strb_o  = data_strb_i;
      end
   end

   // Return the SRAM read data to whichever port owns the pending response.
   always_comb begin
      instr_rvalid_o = rst_ni & pend_valid_q & ~pend_owner_q;
      data_rvalid_o  = rst_ni & pend_valid_q & pend_owner_q;
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
      data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
   end

endmodule
